i2c_slave_regs: RTL and testbench

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_slave_regs_pkg.sv | 5 +
 rtl/i2c_slave_regs_in_filter.sv | 28 ++
 rtl/i2c_slave_regs.sv | 134 +++++++++++++
 tb/tb_i2c_slave_regs.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_regs_pkg.sv
// i2c_slave_regs_pkg: shared state encoding and register bank depth
package i2c_slave_regs_pkg;
  localparam int BANK_DEPTH = 16;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK} state_t;
endpackage

// File: rtl/i2c_slave_regs_in_filter.sv
// i2c_in_filter: 2-flop synchronizer followed by a FILT_LEN-sample glitch filter
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic sysclk_i,
  input  logic reset_n_i,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // accept a new level only after FILT_LEN consecutive differing synchronized samples
  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync <= 2'b11;
      cnt <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) cnt <= '0;
      else if (cnt == CW'(FILT_LEN - 1)) begin
        dout <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target exposing a 16x8 register bank, also host-accessible
module i2c_slave_regs import i2c_slave_regs_pkg::*; #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int FILT_LEN = 3
) (
  input  logic       sysclk_i,
  input  logic       reset_n_i,
  input  logic       wr_ena_i,
  input  logic [3:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [3:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  inout  wire        scl_pin,
  inout  wire        sda_pin,
  output logic       busy_o,
  output logic       wr_done_o
);
  state_t state, nxt;
  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop, last_bit;
  logic cnt_en, shift_in, store, ack_on, ack_off, load, rd_shift, rd_release, rd_sample;
  logic [7:0] bank [BANK_DEPTH];
  logic [7:0] shreg, byte_in;
  logic [2:0] bit_cnt;
  logic [3:0] ptr;
  logic oe, ptr_phase, rd_go;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (.sysclk_i(sysclk_i), .reset_n_i(reset_n_i), .din(scl_pin), .dout(scl_f));
  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (.sysclk_i(sysclk_i), .reset_n_i(reset_n_i), .din(sda_pin), .dout(sda_f));

  assign sda_pin = oe ? 1'b0 : 1'bz;
  assign rd_data_o = bank[rd_addr_i];
  assign scl_rise = scl_f && !scl_d;
  assign scl_fall = !scl_f && scl_d;
  assign start = scl_f && scl_d && sda_d && !sda_f;
  assign stop = scl_f && scl_d && !sda_d && sda_f;
  assign byte_in = {shreg[6:0], sda_f};
  assign last_bit = bit_cnt == 3'd7;

  // state register and previous filtered levels for edge detection
  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      state <= nxt;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // next state; START and STOP override whatever the byte engine is doing
  always_comb begin
    nxt = state;
    case (state)
      ADDR:     if (scl_rise && last_bit) nxt = byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : IDLE;
      ADDR_ACK: if (scl_fall && oe) nxt = shreg[0] ? RD_BYTE : WR_BYTE;
      WR_BYTE:  if (scl_rise && last_bit) nxt = WR_ACK;
      WR_ACK:   if (scl_fall && oe) nxt = WR_BYTE;
      RD_BYTE:  if (scl_rise && last_bit) nxt = RD_ACK;
      RD_ACK:   nxt = scl_rise && sda_f ? IDLE : scl_fall && rd_go ? RD_BYTE : RD_ACK;
      default:  nxt = IDLE;
    endcase
    if (start) nxt = ADDR;
    if (stop) nxt = IDLE;
  end

  // per-state datapath strobes; ACK slots span fall-to-fall, tracked by oe / rd_go
  always_comb begin
    cnt_en = scl_rise && state inside {ADDR, WR_BYTE, RD_BYTE};
    shift_in = scl_rise && state inside {ADDR, WR_BYTE};
    store = scl_rise && last_bit && state == WR_BYTE;
    ack_on = scl_fall && !oe && state inside {ADDR_ACK, WR_ACK};
    ack_off = scl_fall && oe && state inside {ADDR_ACK, WR_ACK};
    load = scl_fall && ((state == ADDR_ACK && oe && shreg[0]) || (state == RD_ACK && rd_go));
    rd_shift = scl_fall && state == RD_BYTE;
    rd_release = scl_fall && state == RD_ACK && !rd_go;
    rd_sample = scl_rise && state == RD_ACK && !sda_f;
  end

  // byte engine, pointer, SDA drive and bank; I2C store is last so it wins over the host
  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < BANK_DEPTH; i++) bank[i] <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      ptr <= '0;
      oe <= 1'b0;
      ptr_phase <= 1'b0;
      rd_go <= 1'b0;
      busy_o <= 1'b0;
      wr_done_o <= 1'b0;
    end else begin
      wr_done_o <= store && !ptr_phase;
      if (start) busy_o <= 1'b1;
      else if (stop) busy_o <= 1'b0;
      if (wr_ena_i) bank[wr_addr_i] <= wr_data_i;
      if (start || stop) begin
        oe <= 1'b0;
        bit_cnt <= '0;
        rd_go <= 1'b0;
      end else begin
        if (state == ADDR) ptr_phase <= 1'b1;
        if (cnt_en) bit_cnt <= bit_cnt + 1'b1;
        if (shift_in) shreg <= byte_in;
        if (ack_on) oe <= 1'b1;
        if (ack_off) oe <= 1'b0;
        if (rd_shift) begin
          shreg <= {shreg[6:0], 1'b0};
          oe <= !shreg[6];
        end
        if (rd_release) oe <= 1'b0;
        if (rd_sample) rd_go <= 1'b1;
        if (load) begin
          shreg <= bank[ptr];
          oe <= !bank[ptr][7];
          ptr <= ptr + 1'b1;
          rd_go <= 1'b0;
          bit_cnt <= '0;
        end
        if (store) begin
          if (ptr_phase) begin
            ptr <= byte_in[3:0];
            ptr_phase <= 1'b0;
          end else begin
            bank[ptr] <= byte_in;
            ptr <= ptr + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master against a transaction-level bank model
module tb_i2c_slave_regs;
  logic clk = 1'b0, rst_n = 1'b0, wr_ena = 1'b0;
  logic [3:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0, rd_data;
  logic busy, wr_done, m_scl = 1'b1, m_sda = 1'b1;
  wire scl_pin, sda_pin;
  int total = 0, bad = 0, done_cnt = 0;
  logic [7:0] m_bank [16];
  int m_ptr = 0;

  assign scl_pin = m_scl;
  assign sda_pin = m_sda ? 1'bz : 1'b0;
  pullup (sda_pin);

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (
    .sysclk_i(clk), .reset_n_i(rst_n), .wr_ena_i(wr_ena), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .scl_pin(scl_pin), .sda_pin(sda_pin), .busy_o(busy), .wr_done_o(wr_done));

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_done) done_cnt++;

  task automatic q(); repeat (10) @(posedge clk); #1; endtask
  task automatic i2c_start(); m_sda = 1; q(); m_scl = 1; q(); m_sda = 0; q(); m_scl = 0; q(); endtask
  task automatic i2c_stop(); m_sda = 0; q(); m_scl = 1; q(); m_sda = 1; q(); q(); endtask
  task automatic bit_xfer(input logic b, output logic s);
    m_sda = b; q(); m_scl = 1; q(); s = sda_pin; q(); m_scl = 0; q();
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, s);
    ack = !s;
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, s); d[i] = s; end
    bit_xfer(!mack, s);
  endtask
  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_ena = 1; @(posedge clk); #1; wr_ena = 0;
    m_bank[a] = d;
  endtask

  task automatic test_reset();
    rst_n = 0; repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
    m_ptr = 0;
    total++; if (sda_pin !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1", sda_pin); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
    @(negedge clk); rst_n = 1; q();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      total++; if (rd_data !== m_bank[i]) begin bad++; $display("FAIL reset_bank[%0d]: got %h want %h", i, rd_data, m_bank[i]); end
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2, s;
    logic [7:0] d0, d1;
    host_wr(4'd7, 8'h3C);
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h07, a1);
    i2c_start(); wr_byte(8'hA1, a2);
    rd_byte(1'b1, d0); rd_byte(1'b0, d1);
    bit_xfer(1'b1, s);
    i2c_stop();
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
    total++; if (d0 !== m_bank[7]) begin bad++; $display("FAIL read_byte0: got %h want %h", d0, m_bank[7]); end
    total++; if (d1 !== m_bank[8]) begin bad++; $display("FAIL read_byte1: got %h want %h", d1, m_bank[8]); end
    total++; if (s !== 1'b1) begin bad++; $display("FAIL read_release_after_nack: got %b want 1", s); end
    m_ptr = 9;
  endtask

  task automatic test_write_basic();
    logic [3:0] acks;
    int d0 = done_cnt;
    i2c_start(); wr_byte(8'hA0, acks[3]); wr_byte(8'h03, acks[2]); wr_byte(8'hA5, acks[1]); wr_byte(8'h5A, acks[0]);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    i2c_stop();
    m_bank[3] = 8'hA5; m_bank[4] = 8'h5A; m_ptr = 5;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    total++; if (acks !== 4'hF) begin bad++; $display("FAIL write_acks: got %b want 1111", acks); end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL write_done_pulses: got %0d want 2", done_cnt - d0); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      total++; if (rd_data !== m_bank[i]) begin bad++; $display("FAIL write_bank[%0d]: got %h want %h", i, rd_data, m_bank[i]); end
    end
  endtask

  task automatic test_write_random();
    for (int it = 0; it < 3; it++) begin
      logic [7:0] pb, d;
      logic a, all_ack;
      int n, d0;
      pb = 8'($urandom()); n = $urandom_range(1, 4); d0 = done_cnt; all_ack = 1;
      m_ptr = int'(pb[3:0]);
      i2c_start(); wr_byte(8'hA0, a); all_ack &= a; wr_byte(pb, a); all_ack &= a;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom()); wr_byte(d, a); all_ack &= a;
        m_bank[m_ptr] = d; m_ptr = (m_ptr + 1) % 16;
      end
      i2c_stop();
      total++; if (all_ack !== 1'b1) begin bad++; $display("FAIL rand_write_acks it%0d: got %b want 1", it, all_ack); end
      total++; if (done_cnt - d0 != n) begin bad++; $display("FAIL rand_write_done it%0d: got %0d want %0d", it, done_cnt - d0, n); end
      for (int i = 0; i < 16; i++) begin
        rd_addr = 4'(i); #1;
        total++; if (rd_data !== m_bank[i]) begin bad++; $display("FAIL rand_write_bank[%0d] it%0d: got %h want %h", i, it, rd_data, m_bank[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    int d0 = done_cnt;
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h0F, a1); wr_byte(8'h11, a2); wr_byte(8'h22, a3); i2c_stop();
    m_bank[15] = 8'h11; m_bank[0] = 8'h22; m_ptr = 1;
    total++; if ({a0, a1, a2, a3} !== 4'hF) begin bad++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL wrap_done: got %0d want 2", done_cnt - d0); end
    rd_addr = 4'hF; #1;
    total++; if (rd_data !== m_bank[15]) begin bad++; $display("FAIL wrap_bank15: got %h want %h", rd_data, m_bank[15]); end
    rd_addr = 4'h0; #1;
    total++; if (rd_data !== m_bank[0]) begin bad++; $display("FAIL wrap_bank0: got %h want %h", rd_data, m_bank[0]); end
  endtask

  task automatic test_bad_addr();
    logic a0, a1, a2;
    int d0 = done_cnt;
    i2c_start(); wr_byte(8'hA2, a0); wr_byte(8'h00, a1); wr_byte(8'hFF, a2); i2c_stop();
    total++; if (a0 !== 1'b0) begin bad++; $display("FAIL badaddr_ack: got %b want 0", a0); end
    total++; if ({a1, a2} !== 2'b00) begin bad++; $display("FAIL badaddr_idle_acks: got %b want 00", {a1, a2}); end
    total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL badaddr_done: got %0d want 0", done_cnt - d0); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      total++; if (rd_data !== m_bank[i]) begin bad++; $display("FAIL badaddr_bank[%0d]: got %h want %h", i, rd_data, m_bank[i]); end
    end
  endtask

  task automatic test_collision();
    logic a0, a1, a2, seen;
    seen = 0;
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h02, a1);
    fork
      wr_byte(8'h77, a2);
      begin
        wr_addr = 4'd2; wr_data = 8'h99; wr_ena = 1;
        for (int k = 0; k < 400 && !seen; k++) begin @(negedge clk); if (wr_done) seen = 1; end
        wr_ena = 0;
      end
    join
    i2c_stop();
    m_bank[2] = 8'h77; m_ptr = 3;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL collide_store_seen: got %b want 1", seen); end
    total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL collide_acks: got %b want 111", {a0, a1, a2}); end
    rd_addr = 4'd2; #1;
    total++; if (rd_data !== m_bank[2]) begin bad++; $display("FAIL collide_bank2: got %h want %h", rd_data, m_bank[2]); end
  endtask

  task automatic test_random_read();
    for (int it = 0; it < 3; it++) begin
      logic [3:0] p;
      logic [7:0] d;
      logic a0, a1, a2;
      int n;
      p = 4'($urandom()); n = $urandom_range(1, 4);
      i2c_start(); wr_byte(8'hA0, a0); wr_byte({4'h0, p}, a1);
      i2c_start(); wr_byte(8'hA1, a2);
      total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL rand_read_acks it%0d: got %b want 111", it, {a0, a1, a2}); end
      m_ptr = int'(p);
      for (int k = 0; k < n; k++) begin
        rd_byte(k != n - 1, d);
        total++; if (d !== m_bank[m_ptr]) begin bad++; $display("FAIL rand_read it%0d byte%0d: got %h want %h", it, k, d, m_bank[m_ptr]); end
        m_ptr = (m_ptr + 1) % 16;
      end
      i2c_stop();
    end
  endtask

  task automatic test_glitch_reset();
    logic s, a0, a1, a2;
    @(posedge clk); #1; m_sda = 0; @(posedge clk); #1; m_sda = 1; q(); q();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_false_start: got busy %b want 0", busy); end
    i2c_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_start_busy: got %b want 1", busy); end
    m_sda = 0; q(); m_scl = 1; q();
    m_sda = 1; @(posedge clk); #1; m_sda = 0; q();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_false_stop: got busy %b want 1", busy); end
    m_scl = 0; q(); i2c_stop();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_real_stop: got busy %b want 0", busy); end
    host_wr(4'd5, 8'h00);
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h05, a1); i2c_start(); wr_byte(8'hA1, a2);
    total++; if (sda_pin !== 1'b0) begin bad++; $display("FAIL rdbyte_drive_before_reset: got %b want 0", sda_pin); end
    rst_n = 0; @(posedge clk); #1;
    total++; if (sda_pin !== 1'b1) begin bad++; $display("FAIL reset_mid_read_sda: got %b want 1", sda_pin); end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
    m_ptr = 0;
    bit_xfer(1'b1, s);
    total++; if (s !== 1'b1) begin bad++; $display("FAIL reset_mid_read_ignored: got %b want 1", s); end
    i2c_stop();
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h01, a1); wr_byte(8'h42, a2); i2c_stop();
    m_bank[1] = 8'h42;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      total++; if (rd_data !== m_bank[i]) begin bad++; $display("FAIL post_reset_bank[%0d]: got %h want %h", i, rd_data, m_bank[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_basic();
    test_write_random();
    test_wrap();
    test_bad_addr();
    test_collision();
    test_random_read();
    test_glitch_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
